// File: rtl/perf_event_collector_if.sv
// Bundle of event, configuration, counter-write and read request/response
// signals for perf_event_collector. The collector uses the slave modport;
// the agent driving events, config and reads uses the master modport.
interface perf_event_collector_if #(
  parameter int EVENT_NUM   = 16,
  parameter int INC_WIDTH   = 2,
  parameter int COUNTER_NUM = 4,
  parameter int CNT_WIDTH   = 32
);
  localparam int IDX_W = $clog2(COUNTER_NUM);
  localparam int SEL_W = $clog2(EVENT_NUM);

  // Per-cycle event increments and global count inhibit
  logic [EVENT_NUM*INC_WIDTH-1:0] event_inc;
  logic                           freeze;

  // Counter configuration
  logic                           cfg_we;
  logic [IDX_W-1:0]               cfg_idx;
  logic [SEL_W-1:0]               cfg_sel;
  logic                           cfg_en;

  // Counter value write
  logic                           cnt_we;
  logic [IDX_W-1:0]               cnt_idx;
  logic [CNT_WIDTH-1:0]           cnt_wdata;

  // Read request / response
  logic                           rd_valid;
  logic [IDX_W-1:0]               rd_idx;
  logic                           rd_ready;
  logic                           resp_valid;
  logic [CNT_WIDTH-1:0]           resp_data;
  logic                           resp_ovf;
  logic                           resp_ready;

  // Sticky overflow flags
  logic [COUNTER_NUM-1:0]         ovf;

  modport master (
    output event_inc, freeze,
    output cfg_we, cfg_idx, cfg_sel, cfg_en,
    output cnt_we, cnt_idx, cnt_wdata,
    output rd_valid, rd_idx, resp_ready,
    input  rd_ready, resp_valid, resp_data, resp_ovf, ovf
  );

  modport slave (
    input  event_inc, freeze,
    input  cfg_we, cfg_idx, cfg_sel, cfg_en,
    input  cnt_we, cnt_idx, cnt_wdata,
    input  rd_valid, rd_idx, resp_ready,
    output rd_ready, resp_valid, resp_data, resp_ovf, ovf
  );
endinterface

// File: rtl/perf_event_collector.sv
// Programmable performance counters: each counter accumulates one selected event source.
// Latency: event visible in counter 2 cycles after it is raised; read response 1 cycle after accept.
// Backpressure: single response buffer; a new read is accepted when the buffer is empty or being drained.
module perf_event_collector #(
  parameter int EVENT_NUM   = 16,
  parameter int INC_WIDTH   = 2,
  parameter int COUNTER_NUM = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  perf_event_collector_if.slave  bus
);
  localparam int SEL_W = $clog2(EVENT_NUM);
  localparam int SUM_W = CNT_WIDTH + 1;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  logic [INC_WIDTH-1:0]   r_event_q [EVENT_NUM];
  logic [CNT_WIDTH-1:0]   r_cnt     [COUNTER_NUM];
  logic [SEL_W-1:0]       r_sel     [COUNTER_NUM];
  logic [COUNTER_NUM-1:0] r_en;
  logic [COUNTER_NUM-1:0] r_ovf;

  state_t                 r_state;
  logic                   r_resp_vld;
  logic [CNT_WIDTH-1:0]   r_resp_data;
  logic                   r_resp_ovf;

  logic [SUM_W-1:0]       w_sum [COUNTER_NUM];
  logic                   w_cfg_ok;
  logic                   w_cnt_ok;
  logic                   w_rd_ok;
  logic [CNT_WIDTH-1:0]   w_rd_data;
  logic                   w_rd_ovf;
  logic                   w_rd_accept;

  // Indices beyond the implemented counters are ignored on write and read as zero
  assign w_cfg_ok = (32'(bus.cfg_idx) < COUNTER_NUM);
  assign w_cnt_ok = (32'(bus.cnt_idx) < COUNTER_NUM);
  assign w_rd_ok  = (32'(bus.rd_idx)  < COUNTER_NUM);

  assign bus.rd_ready   = !r_resp_vld || bus.resp_ready;
  assign w_rd_accept    = bus.rd_valid && bus.rd_ready;
  assign bus.resp_valid = r_resp_vld;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_ovf   = r_resp_ovf;
  assign bus.ovf        = r_ovf;

  // Register all event increments unconditionally to cut the fan-in timing path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < EVENT_NUM; e++) r_event_q[e] <= '0;
    end else begin
      for (int e = 0; e < EVENT_NUM; e++) r_event_q[e] <= bus.event_inc[e*INC_WIDTH +: INC_WIDTH];
    end
  end

  // Next count per counter with carry-out in the extra top bit
  always_comb begin
    for (int i = 0; i < COUNTER_NUM; i++) begin
      w_sum[i] = {1'b0, r_cnt[i]} + SUM_W'(r_event_q[r_sel[i]]);
    end
  end

  // Counter configuration: selection and enable, leaving value and overflow alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COUNTER_NUM; i++) r_sel[i] <= '0;
      r_en <= '0;
    end else if (bus.cfg_we && w_cfg_ok) begin
      r_sel[bus.cfg_idx] <= bus.cfg_sel;
      r_en[bus.cfg_idx]  <= bus.cfg_en;
    end
  end

  // Counter accumulation; a software write overrides that cycle's increment and clears overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COUNTER_NUM; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < COUNTER_NUM; i++) begin
        if (bus.cnt_we && w_cnt_ok && (32'(bus.cnt_idx) == i)) begin
          r_cnt[i] <= bus.cnt_wdata;
          r_ovf[i] <= 1'b0;
        end else if (r_en[i] && !bus.freeze) begin
          r_cnt[i] <= w_sum[i][CNT_WIDTH-1:0];
          if (w_sum[i][CNT_WIDTH]) r_ovf[i] <= 1'b1;
        end
      end
    end
  end

  // Read mux sees pre-update state so a read racing a write returns the old value
  always_comb begin
    w_rd_data = '0;
    w_rd_ovf  = 1'b0;
    if (w_rd_ok) begin
      w_rd_data = r_cnt[bus.rd_idx];
      w_rd_ovf  = r_ovf[bus.rd_idx];
    end
  end

  // Response buffer: EMPTY/FULL with registered valid, data and overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_resp_vld  <= 1'b0;
      r_resp_data <= '0;
      r_resp_ovf  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_rd_accept) begin
            r_state     <= ST_FULL;
            r_resp_vld  <= 1'b1;
            r_resp_data <= w_rd_data;
            r_resp_ovf  <= w_rd_ovf;
          end
        end
        ST_FULL: begin
          if (w_rd_accept) begin
            r_resp_data <= w_rd_data;
            r_resp_ovf  <= w_rd_ovf;
          end else if (bus.resp_ready) begin
            r_state    <= ST_EMPTY;
            r_resp_vld <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_resp_vld <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_perf_event_collector.sv
// Self-checking bench for perf_event_collector: directed scenarios plus a random
// run, all compared against a per-counter arithmetic model of the counter set.
module tb_perf_event_collector;
  localparam int EN = 16;
  localparam int IW = 2;
  localparam int CN = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  perf_event_collector_if #(.EVENT_NUM(EN), .INC_WIDTH(IW), .COUNTER_NUM(CN), .CNT_WIDTH(CW)) bus ();

  perf_event_collector #(.EVENT_NUM(EN), .INC_WIDTH(IW), .COUNTER_NUM(CN), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  int unsigned    m_evq [EN];
  logic [CW-1:0]  m_cnt [CN];
  bit             m_ovf [CN];
  int unsigned    m_sel [CN];
  bit             m_en  [CN];
  bit             m_rv;
  logic [CW-1:0]  m_rd;
  bit             m_ro;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [CN-1:0] m_ovf_vec();
    logic [CN-1:0] v;
    for (int i = 0; i < CN; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < EN; e++) m_evq[e] = 0;
    for (int i = 0; i < CN; i++) begin
      m_cnt[i] = '0; m_ovf[i] = 0; m_sel[i] = 0; m_en[i] = 0;
    end
    m_rv = 0; m_rd = '0; m_ro = 0;
  endtask

  task automatic idle_inputs();
    bus.event_inc = '0; bus.freeze = 0;
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_sel = '0; bus.cfg_en = 0;
    bus.cnt_we = 0; bus.cnt_idx = '0; bus.cnt_wdata = '0;
    bus.rd_valid = 0; bus.rd_idx = '0; bus.resp_ready = 1;
  endtask

  // Advance one clock: compute the model's next state from current inputs, then step.
  task automatic cycle();
    logic [CW-1:0]     n_cnt [CN];
    bit                n_ovf [CN];
    int unsigned       n_sel [CN];
    bit                n_en  [CN];
    int unsigned       n_evq [EN];
    bit                n_rv, n_ro, rdy;
    logic [CW-1:0]     n_rd;
    longint unsigned   s;
    int                idx;
    n_cnt = m_cnt; n_ovf = m_ovf; n_sel = m_sel; n_en = m_en;
    n_rv = m_rv; n_rd = m_rd; n_ro = m_ro;
    rdy = !m_rv || bus.resp_ready;
    idx = int'(bus.rd_idx);
    if (bus.rd_valid && rdy) begin
      n_rv = 1;
      n_rd = (idx < CN) ? m_cnt[idx] : '0;
      n_ro = (idx < CN) ? m_ovf[idx] : 0;
    end else if (m_rv && bus.resp_ready) begin
      n_rv = 0;
    end
    for (int i = 0; i < CN; i++) begin
      if (bus.cnt_we && int'(bus.cnt_idx) == i) begin
        n_cnt[i] = bus.cnt_wdata; n_ovf[i] = 0;
      end else if (m_en[i] && !bus.freeze) begin
        s = 0; s = m_cnt[i]; s = s + m_evq[m_sel[i]];
        n_cnt[i] = s[CW-1:0];
        if (s >= 64'h1_0000_0000) n_ovf[i] = 1;
      end
    end
    if (bus.cfg_we && int'(bus.cfg_idx) < CN) begin
      n_sel[bus.cfg_idx] = bus.cfg_sel; n_en[bus.cfg_idx] = bus.cfg_en;
    end
    for (int e = 0; e < EN; e++) n_evq[e] = bus.event_inc[e*IW +: IW];
    @(posedge clk);
    m_cnt = n_cnt; m_ovf = n_ovf; m_sel = n_sel; m_en = n_en; m_evq = n_evq;
    m_rv = n_rv; m_rd = n_rd; m_ro = n_ro;
    #1;
  endtask

  task automatic issue_read(input int idx);
    bus.rd_valid = 1; bus.rd_idx = idx[1:0]; bus.resp_ready = 1;
    cycle();
    bus.rd_valid = 0;
  endtask

  function automatic logic [EN*IW-1:0] one_event(input int e, input int inc);
    logic [EN*IW-1:0] v;
    v = '0;
    v[e*IW +: IW] = inc[IW-1:0];
    return v;
  endfunction

  task automatic test_reset();
    idle_inputs();
    model_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid got %0b want 0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== '0) begin n_errors++; $display("FAIL reset_resp_data got %0h want 0", bus.resp_data); end
    n_checks++; if (bus.resp_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_resp_ovf got %0b want 0", bus.resp_ovf); end
    n_checks++; if (bus.ovf !== '0) begin n_errors++; $display("FAIL reset_ovf got %0h want 0", bus.ovf); end
    n_checks++; if (bus.rd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_rd_ready got %0b want 1", bus.rd_ready); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_basic_count();
    bus.cfg_we = 1; bus.cfg_idx = 0; bus.cfg_sel = 3; bus.cfg_en = 1;
    cycle();
    bus.cfg_we = 0;
    bus.event_inc = one_event(3, 1);
    repeat (10) cycle();
    bus.event_inc = '0;
    repeat (2) cycle();
    issue_read(0);
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_errors++; $display("FAIL basic_resp_valid got %0b want 1", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== 32'd10 || m_rd !== 32'd10) begin n_errors++; $display("FAIL basic_count got %0d want 10 (model %0d)", bus.resp_data, m_rd); end
    n_checks++; if (bus.resp_ovf !== 1'b0) begin n_errors++; $display("FAIL basic_ovf got %0b want 0", bus.resp_ovf); end
  endtask

  task automatic test_latency();
    logic [CW-1:0] want [3];
    want[0] = 0; want[1] = 0; want[2] = 2;
    bus.cfg_we = 1; bus.cfg_idx = 3; bus.cfg_sel = 9; bus.cfg_en = 1;
    cycle();
    bus.cfg_we = 0;
    bus.event_inc = one_event(9, 2);
    bus.rd_valid = 1; bus.rd_idx = 3; bus.resp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      bus.event_inc = '0;
      n_checks++; if (bus.resp_data !== want[k] || m_rd !== want[k]) begin n_errors++; $display("FAIL latency_%0d got %0d want %0d", k, bus.resp_data, want[k]); end
    end
    bus.rd_valid = 0;
    cycle();
  endtask

  task automatic test_multi_issue_freeze();
    bus.cfg_we = 1; bus.cfg_idx = 1; bus.cfg_sel = 5; bus.cfg_en = 1;
    cycle();
    bus.cfg_we = 0;
    bus.event_inc = one_event(5, 3);
    repeat (4) cycle();
    bus.event_inc = '0;
    repeat (2) cycle();
    issue_read(1);
    n_checks++; if (bus.resp_data !== 32'd12 || m_rd !== 32'd12) begin n_errors++; $display("FAIL multi_issue got %0d want 12", bus.resp_data); end
    bus.cnt_we = 1; bus.cnt_idx = 1; bus.cnt_wdata = 0;
    cycle();
    bus.cnt_we = 0;
    for (int k = 0; k < 6; k++) begin
      bus.event_inc = (k < 4) ? one_event(5, 3) : '0;
      bus.freeze = (k == 1 || k == 2);
      cycle();
    end
    bus.freeze = 0; bus.event_inc = '0;
    repeat (2) cycle();
    issue_read(1);
    n_checks++; if (bus.resp_data !== 32'd6 || m_rd !== 32'd6) begin n_errors++; $display("FAIL freeze_count got %0d want 6", bus.resp_data); end
  endtask

  task automatic test_overflow();
    bus.cfg_we = 1; bus.cfg_idx = 2; bus.cfg_sel = 7; bus.cfg_en = 1;
    bus.cnt_we = 1; bus.cnt_idx = 2; bus.cnt_wdata = 32'hFFFF_FFFE;
    cycle();
    bus.cfg_we = 0; bus.cnt_we = 0;
    bus.event_inc = one_event(7, 3);
    cycle();
    bus.event_inc = '0;
    repeat (2) cycle();
    n_checks++; if (bus.ovf[2] !== 1'b1) begin n_errors++; $display("FAIL ovf_set got %0b want 1", bus.ovf[2]); end
    issue_read(2);
    n_checks++; if (bus.resp_data !== 32'd1 || m_rd !== 32'd1) begin n_errors++; $display("FAIL wrap_value got %0h want 1", bus.resp_data); end
    n_checks++; if (bus.resp_ovf !== 1'b1) begin n_errors++; $display("FAIL wrap_resp_ovf got %0b want 1", bus.resp_ovf); end
    bus.cnt_we = 1; bus.cnt_idx = 2; bus.cnt_wdata = 0;
    cycle();
    bus.cnt_we = 0;
    n_checks++; if (bus.ovf[2] !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got %0b want 0", bus.ovf[2]); end
    bus.cnt_we = 1; bus.cnt_idx = 2; bus.cnt_wdata = 32'hFFFF_FFFF;
    cycle();
    bus.cnt_we = 0;
    bus.event_inc = one_event(7, 2);
    cycle();
    bus.event_inc = '0;
    repeat (2) cycle();
    issue_read(2);
    n_checks++; if (bus.resp_data !== 32'd1 || bus.resp_ovf !== 1'b1) begin n_errors++; $display("FAIL wrap_by_two got %0h/%0b want 1/1", bus.resp_data, bus.resp_ovf); end
  endtask

  task automatic test_write_wins();
    logic [CW-1:0] pre;
    bus.event_inc = one_event(3, 1);
    repeat (3) cycle();
    pre = m_cnt[0];
    bus.cnt_we = 1; bus.cnt_idx = 0; bus.cnt_wdata = 100;
    bus.rd_valid = 1; bus.rd_idx = 0; bus.resp_ready = 1;
    cycle();
    bus.cnt_we = 0;
    n_checks++; if (bus.resp_data !== pre) begin n_errors++; $display("FAIL read_before_write got %0d want %0d", bus.resp_data, pre); end
    cycle();
    n_checks++; if (bus.resp_data !== 32'd100) begin n_errors++; $display("FAIL write_wins got %0d want 100", bus.resp_data); end
    cycle();
    n_checks++; if (bus.resp_data !== 32'd101) begin n_errors++; $display("FAIL write_then_count got %0d want 101", bus.resp_data); end
    bus.rd_valid = 0; bus.event_inc = '0;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] first;
    bus.resp_ready = 0; bus.rd_valid = 1; bus.rd_idx = 1;
    #1;
    n_checks++; if (bus.rd_ready !== 1'b1) begin n_errors++; $display("FAIL bp_first_ready got %0b want 1", bus.rd_ready); end
    cycle();
    first = bus.resp_data;
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== m_rd) begin n_errors++; $display("FAIL bp_first_resp got %0h want %0h", bus.resp_data, m_rd); end
    bus.rd_idx = 2;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus.rd_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall_ready got %0b want 0", bus.rd_ready); end
      cycle();
      n_checks++; if (bus.resp_data !== first || bus.resp_valid !== 1'b1) begin n_errors++; $display("FAIL bp_stable got %0h want %0h", bus.resp_data, first); end
    end
    bus.resp_ready = 1;
    #1;
    n_checks++; if (bus.rd_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready got %0b want 1", bus.rd_ready); end
    cycle();
    n_checks++; if (bus.resp_data !== m_rd || m_rd !== m_cnt[2]) begin n_errors++; $display("FAIL bp_second got %0h want %0h", bus.resp_data, m_rd); end
    for (int i = 0; i < CN; i++) begin
      bus.rd_idx = i[1:0];
      cycle();
      n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== m_rd || bus.resp_ovf !== m_ro) begin n_errors++; $display("FAIL b2b_read_%0d got %0h/%0b want %0h/%0b", i, bus.resp_data, bus.resp_ovf, m_rd, m_ro); end
    end
    bus.rd_valid = 0;
    cycle();
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got %0b want 0", bus.resp_valid); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.event_inc = {$urandom, $urandom};
      bus.freeze = ($urandom_range(0, 7) == 0);
      bus.cfg_we = ($urandom_range(0, 9) == 0);
      bus.cfg_idx = 2'($urandom_range(0, 3));
      bus.cfg_sel = 4'($urandom_range(0, 15));
      bus.cfg_en = ($urandom_range(0, 3) != 0);
      bus.cnt_we = ($urandom_range(0, 11) == 0);
      bus.cnt_idx = 2'($urandom_range(0, 3));
      bus.cnt_wdata = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      bus.rd_valid = ($urandom_range(0, 1) == 0);
      bus.rd_idx = 2'($urandom_range(0, 3));
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n_checks++;
      if (bus.resp_valid !== m_rv || (m_rv && (bus.resp_data !== m_rd || bus.resp_ovf !== m_ro))
          || bus.ovf !== m_ovf_vec() || bus.rd_ready !== (!m_rv || bus.resp_ready)) begin
        n_errors++;
        $display("FAIL random_%0d got v%0b d%0h o%0b ovf%0h want v%0b d%0h o%0b ovf%0h", k,
                 bus.resp_valid, bus.resp_data, bus.resp_ovf, bus.ovf, m_rv, m_rd, m_ro, m_ovf_vec());
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_async_reset();
    bus.cfg_we = 1; bus.cfg_idx = 0; bus.cfg_sel = 3; bus.cfg_en = 1;
    bus.cnt_we = 1; bus.cnt_idx = 0; bus.cnt_wdata = 32'h55;
    cycle();
    bus.cfg_we = 0; bus.cnt_we = 0;
    bus.rd_valid = 1; bus.rd_idx = 0; bus.resp_ready = 0;
    cycle();
    bus.rd_valid = 0;
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h55) begin n_errors++; $display("FAIL pre_reset_resp got %0b/%0h want 1/55", bus.resp_valid, bus.resp_data); end
    #2;
    rst = 1;
    #1;
    model_reset();
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== '0 || bus.resp_ovf !== 1'b0 || bus.ovf !== '0) begin n_errors++; $display("FAIL async_reset got v%0b d%0h o%0b ovf%0h want all 0", bus.resp_valid, bus.resp_data, bus.resp_ovf, bus.ovf); end
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    idle_inputs();
    bus.event_inc = one_event(3, 1);
    bus.rd_valid = 1;
    for (int i = 0; i < CN; i++) begin
      bus.rd_idx = i[1:0];
      cycle();
      n_checks++; if (bus.resp_data !== '0 || m_rd !== '0) begin n_errors++; $display("FAIL post_reset_cnt_%0d got %0h want 0", i, bus.resp_data); end
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_latency();
    test_multi_issue_freeze();
    test_overflow();
    test_write_wins();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/perf_event_collector.md
# perf_event_collector

Hardware performance-counter block that consumes per-cycle event pulses raised throughout the core (the same conditions fed to per-module perf counters) and accumulates them into a small set of programmable counters. Each counter selects one event source and is read out through a valid/ready request/response port, so counts are observable by software and by the difftest harness without per-module counters. Sits downstream of all event producers and upstream of the CSR/debug read path.

## Interface
- EVENT_NUM, 16, number of event sources
- INC_WIDTH, 2, bits per event increment (multi-issue events report 0..3 per cycle)
- COUNTER_NUM, 4, number of programmable counters
- CNT_WIDTH, 32, counter width
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- event_inc  input  EVENT_NUM*INC_WIDTH  packed per-event increment, event e at [e*INC_WIDTH +: INC_WIDTH]
- freeze  input  1  global count inhibit
- cfg_we  input  1  config write strobe
- cfg_idx  input  $clog2(COUNTER_NUM)  counter being configured
- cfg_sel  input  $clog2(EVENT_NUM)  event select
- cfg_en  input  1  counter enable
- cnt_we  input  1  counter value write strobe
- cnt_idx  input  $clog2(COUNTER_NUM)  counter being written
- cnt_wdata  input  CNT_WIDTH  value written
- rd_valid  input  1  read request
- rd_idx  input  $clog2(COUNTER_NUM)  counter to read
- rd_ready  output  1  read request accepted
- resp_valid  output  1  response held
- resp_data  output  CNT_WIDTH  counter value
- resp_ovf  output  1  sticky overflow flag of read counter
- resp_ready  input  1  response consumed
- ovf  output  COUNTER_NUM  sticky overflow flags

## Operation
- Input stage: event_inc registered into event_q every cycle (unconditional); counters use event_q only.
- Per counter i: if en[i] and !freeze, cnt[i] <= cnt[i] + event_q[sel[i]] (zero-extended); carry-out sets ovf[i] (sticky), counter wraps modulo 2^CNT_WIDTH.
- cfg_we: sel[cfg_idx] <= cfg_sel, en[cfg_idx] <= cfg_en; counter value and ovf unchanged. New selection takes effect from the next cycle's increment.
- cnt_we: cnt[cnt_idx] <= cnt_wdata, ovf[cnt_idx] <= 0; that cycle's increment for that counter is discarded (write wins).
- Indices >= COUNTER_NUM (non-power-of-two configs): writes ignored, reads return data 0, ovf 0.
- Response buffer, states EMPTY (resp_valid=0) / FULL (resp_valid=1).
  - rd_ready = !resp_valid || resp_ready (combinational).
  - rd_valid && rd_ready: capture cnt[rd_idx] and ovf[rd_idx] as registered before this cycle's update (read-before-write); go/stay FULL.
  - FULL && resp_ready && !rd_valid: go EMPTY.
  - resp_data/resp_ovf stable while FULL and !resp_ready.
- freeze affects counting only; config, writes, and reads proceed.

## Timing
- Reset values: event_q 0, all cnt 0, sel 0, en 0, ovf 0, resp_valid 0, resp_data 0, resp_ovf 0.
- Event at cycle t on event_inc appears in cnt at end of cycle t+1 (visible to a read accepted at t+2).
- Read latency 1: accept at cycle t -> resp_valid at t+1. Back-to-back reads sustain 1 per cycle when resp_ready held 1.
- Simultaneous cnt_we and rd on same counter: response returns pre-write value.
- Simultaneous cfg_we and cnt_we on same counter: both applied.
- Wrap: cnt=2^CNT_WIDTH-1 plus increment 2 -> cnt=1, ovf=1 same edge.
- Reset asserted mid-operation: all state returns to reset values asynchronously; a pending response is dropped.

## Test plan
- Reset then cfg counter0 sel=3 en=1; drive event 3 inc=1 for 10 cycles -> read counter0 after 2 idle cycles returns 10, resp_ovf 0.
- Multi-issue: event 5 inc=3 for 4 cycles, counter1 sel=5 -> 12; assert freeze for 2 of those cycles (aligned to event_q) -> 6.
- Overflow: cnt_we counter2 = 0xFFFF_FFFE, event inc=3 for one cycle -> cnt=0x0000_0001, ovf[2]=1; then cnt_we 0 -> ovf[2]=0.
- Write vs increment same cycle: counter0 counting inc=1, cnt_we=100 -> next cycle value 100, then 101.
- Backpressure: resp_ready=0, two rd_valid requests -> first accepted, rd_ready=0 for second until resp_ready=1; resp_data stable throughout; then back-to-back reads of counters 0..3 return one per cycle.
- Async reset while resp_valid=1 and counters nonzero -> all outputs 0 immediately, counters 0 after release.
